// File: rtl/lbmem_pkg.sv
// Shared types and width helpers for the lbmem line buffer.
package lbmem_pkg;

  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  // count must hold DEPTH itself, so it needs one bit more than an address
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lbmem_if.sv
// Producer/consumer bus of the line buffer; slave side is the buffer itself.
interface lbmem_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
);
  import lbmem_pkg::*;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic             flush;
  logic             rdy;
  logic [WIDTH-1:0] rdata;
  logic             valid;
  logic             full;
  logic             overflow;
  logic [CW-1:0]    count;

  modport master (output wdata, wen, flush, rdy,
                  input  rdata, valid, full, overflow, count);
  modport slave  (input  wdata, wen, flush, rdy,
                  output rdata, valid, full, overflow, count);
endinterface

// File: rtl/lbmem_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module lbmem_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/lbmem_n.sv
// Line-buffer control: holds output silent until LAG words are buffered,
// then streams under valid/rdy and drains to empty before re-arming.
module lbmem_n
  import lbmem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int LAG   = 8
) (
  input logic    CLK,
  input logic    RESETN,
  lbmem_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d, cnt_acc;
  logic [AW-1:0] waddr_q, waddr_d, raddr;
  logic          ovf_q, ovf_d;
  logic          valid, full, fire, acc;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    cnt_acc = count_q + CW'(acc);
    count_d = cnt_acc - CW'(fire);
    state_d = state_q;
    unique case (state_q)
      FILL:    if (cnt_acc >= CW'(LAG)) state_d = STREAM;
      STREAM:  if (count_d == '0)       state_d = FILL;
      default: state_d = FILL;
    endcase
    if (bus.flush) begin
      state_d = FILL;
      count_d = '0;
    end
  end

  // A full buffer still accepts a write when the oldest slot is read out
  // in the same cycle: the new word lands in the slot being vacated.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    valid = (state_q == STREAM) && (count_q != '0);
    fire  = valid & bus.rdy;
    acc   = bus.wen & ~bus.flush & (~full | fire);
  end

  assign waddr_d = acc ? waddr_q + AW'(1) : waddr_q;
  assign ovf_d   = bus.flush ? 1'b0 : (ovf_q | (bus.wen & full & ~fire));
  assign raddr   = waddr_q - count_q[AW-1:0];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count_q <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
    end
  end

  lbmem_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (CLK),
    .we_i    (acc),
    .waddr_i (waddr_q),
    .wdata_i (bus.wdata),
    .raddr_i (raddr),
    .rdata_o (bus.rdata)
  );

  assign bus.valid    = valid;
  assign bus.full     = full;
  assign bus.overflow = ovf_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_lbmem_n.sv
// Directed scenarios for lbmem_n at WIDTH=16, DEPTH=64, LAG=8.
module tb_lbmem_n;
  localparam int W = 16;
  localparam int D = 64;
  localparam int L = 8;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lbmem_if #(.WIDTH(W), .DEPTH(D)) bus ();
  lbmem_n #(.WIDTH(W), .DEPTH(D), .LAG(L)) dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.wen = 1'b0; bus.flush = 1'b0; bus.rdy = 1'b0; bus.wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    RESETN = 1'b0;
    tick(); tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.count !== 7'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset got v=%0b c=%0d f=%0b o=%0b want 0 0 0 0",
               bus.valid, bus.count, bus.full, bus.overflow);
    end
    RESETN = 1'b1;
    tick();
  endtask

  // Writes base..base+L-1 with rdy high from an empty FILL state.
  task automatic test_fill(input int base);
    bus.rdy = 1'b1;
    bus.wen = 1'b1;
    for (int k = 0; k < L; k++) begin
      bus.wdata = 16'(base + k);
      tick();
      if (k < L - 1) begin
        checks++;
        if (bus.valid !== 1'b0 || bus.count !== 7'(k + 1)) begin
          errors++;
          $display("FAIL fill_k%0d got v=%0b c=%0d want v=0 c=%0d", k, bus.valid, bus.count, k + 1);
        end
      end
    end
    bus.wen = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.rdata !== 16'(base) || bus.count !== 7'd8) begin
      errors++;
      $display("FAIL fill_done got v=%0b d=%0d c=%0d want v=1 d=%0d c=8",
               bus.valid, bus.rdata, bus.count, base);
    end
  endtask

  task automatic test_drain();
    bus.wen = 1'b0;
    bus.rdy = 1'b1;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.rdata !== 16'(i)) begin
        errors++;
        $display("FAIL drain_%0d got v=%0b d=%0d want v=1 d=%0d", i, bus.valid, bus.rdata, i);
      end
      tick();
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.count !== 7'd0) begin
      errors++;
      $display("FAIL drain_empty got v=%0b c=%0d want 0 0", bus.valid, bus.count);
    end
    test_fill(100);
    idle();
  endtask

  task automatic test_stream();
    do_reset();
    bus.rdy = 1'b1;
    bus.wen = 1'b1;
    for (int n = 0; n < 200; n++) begin
      bus.wdata = 16'(n);
      if (n >= L) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.rdata !== 16'(n - L) || bus.count !== 7'd8) begin
          errors++;
          $display("FAIL stream_%0d got v=%0b d=%0d c=%0d want v=1 d=%0d c=8",
                   n, bus.valid, bus.rdata, bus.count, n - L);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    bus.wen = 1'b1;
    for (int k = 0; k < D; k++) begin
      bus.wdata = 16'(k);
      tick();
      if (k == D - 2) begin
        checks++;
        if (bus.full !== 1'b0 || bus.count !== 7'd63) begin
          errors++;
          $display("FAIL full_63 got f=%0b c=%0d want f=0 c=63", bus.full, bus.count);
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 7'd64 || bus.valid !== 1'b1 ||
        bus.rdata !== 16'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_64 got f=%0b c=%0d v=%0b d=%0d o=%0b want 1 64 1 0 0",
               bus.full, bus.count, bus.valid, bus.rdata, bus.overflow);
    end
    bus.wdata = 16'd99;
    tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.rdata !== 16'd0 || bus.count !== 7'd64) begin
      errors++;
      $display("FAIL overflow got o=%0b d=%0d c=%0d want 1 0 64", bus.overflow, bus.rdata, bus.count);
    end
    bus.rdy = 1'b1;
    bus.wdata = 16'd64;
    tick();
    bus.wen = 1'b0;
    bus.rdy = 1'b0;
    checks++;
    if (bus.count !== 7'd64 || bus.rdata !== 16'd1 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_rw got c=%0d d=%0d f=%0b o=%0b want 64 1 1 1",
               bus.count, bus.rdata, bus.full, bus.overflow);
    end
  endtask

  // Runs straight after test_full: buffer full, overflow set, waddr at 1.
  task automatic test_flush_full();
    bus.flush = 1'b1;
    bus.wen = 1'b1;
    bus.wdata = 16'd77;
    tick();
    idle();
    checks++;
    if (bus.count !== 7'd0 || bus.valid !== 1'b0 || bus.full !== 1'b0 ||
        bus.overflow !== 1'b0 || dut.waddr_q !== 6'd1) begin
      errors++;
      $display("FAIL flush_full got c=%0d v=%0b f=%0b o=%0b wa=%0d want 0 0 0 0 1",
               bus.count, bus.valid, bus.full, bus.overflow, dut.waddr_q);
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.wen = 1'b1;
    for (int k = 0; k < L; k++) begin
      bus.wdata = 16'(k);
      tick();
    end
    checks++;
    if (bus.count !== 7'd8 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got c=%0d v=%0b want 8 1", bus.count, bus.valid);
    end
    bus.flush = 1'b1;
    bus.wdata = 16'd55;
    tick();
    idle();
    checks++;
    if (bus.valid !== 1'b0 || bus.count !== 7'd0 || bus.overflow !== 1'b0 || dut.waddr_q !== 6'd8) begin
      errors++;
      $display("FAIL flush got v=%0b c=%0d o=%0b wa=%0d want 0 0 0 8",
               bus.valid, bus.count, bus.overflow, dut.waddr_q);
    end
    test_fill(200);
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.wen = 1'b1;
    for (int k = 0; k < L; k++) begin
      bus.wdata = 16'(k);
      tick();
    end
    bus.wen = 1'b0;
    bus.rdy = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.count !== 7'd5 || bus.valid !== 1'b1 || bus.rdata !== 16'd3) begin
      errors++;
      $display("FAIL areset_pre got c=%0d v=%0b d=%0d want 5 1 3", bus.count, bus.valid, bus.rdata);
    end
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.count !== 7'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL areset got v=%0b c=%0d f=%0b o=%0b want 0 0 0 0",
               bus.valid, bus.count, bus.full, bus.overflow);
    end
    #2 RESETN = 1'b1;
    idle();
    test_fill(0);
    idle();
  endtask

  initial begin
    test_reset();
    test_fill(0);
    test_drain();
    test_stream();
    test_full();
    test_flush_full();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lbmem_n.md
# lbmem_n

Parametrised line-buffer memory for streaming pixel pipelines. Words are written at a free-running write pointer and emitted in write order. The output stays silent until LAG words have accumulated. It then streams under an explicit consumer-ready handshake and drains fully before re-arming. The block sits between a line-rate producer and a stencil/window stage. It generalises the fixed 16×64, lag-8 line buffer with configurable width, depth and lag, back-pressure, a full flag, a sticky overflow flag, synchronous flush and asynchronous reset.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 64, storage words; power of two, ≥ 2
- LAG, 8, words buffered before output becomes valid; 1 ≤ LAG ≤ DEPTH
- CLK  in  1  clock, all state on rising edge
- RESETN  in  1  reset, asynchronous, active-low
- wdata  in  WIDTH  write data
- wen  in  1  write request
- flush  in  1  synchronous clear of buffered contents
- rdy  in  1  consumer ready
- rdata  out  WIDTH  oldest buffered word; meaningful only while valid=1
- valid  out  1  rdata holds a word; transfer when valid & rdy
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a write was dropped because the buffer was full
- count  out  clog2(DEPTH)+1  words currently buffered

## Operation
- Pointers and memory:
  - waddr is clog2(DEPTH) bits and wraps modulo DEPTH.
  - raddr = waddr − count, modulo DEPTH.
  - rdata = mem[raddr], read combinationally.
- Signal definitions:
  - fire = valid & rdy.
  - acc = wen & !flush & (!full | fire): a write is accepted when full only if a read fires in the same cycle.
  - On acc: mem[waddr] ← wdata and waddr ← waddr+1.
- State FILL (reset state):
  - valid = 0.
  - count ← count + acc.
  - Go to STREAM when count + acc ≥ LAG.
- State STREAM:
  - valid = (count != 0).
  - count ← count + acc − fire.
  - Go to FILL when count + acc − fire == 0.
  - With rdy and wen held high continuously, count stays at LAG. Each output word is the one written LAG accepted writes earlier.
- flush has priority over everything else:
  - count ← 0, state ← FILL, overflow ← 0.
  - wen in the same cycle is dropped and waddr is unchanged.
  - overflow is not set by a write dropped this way.
- overflow ← 1 when wen & full & !fire & !flush. It is cleared only by flush or reset.
- Memory contents are not reset. rdata is don't-care while valid=0.

## Timing
- Reset (RESETN low, asynchronous): state FILL, count 0, waddr 0, valid 0, full 0, overflow 0. This is also the required result when reset is asserted mid-stream.
- Fill latency: valid rises on the clock edge that accepts the LAG-th write. It is visible in the following cycle with rdata = first word written.
- Read latency is zero: rdata and valid reflect the registered count/waddr in the same cycle.
- Wrap-around: pointers wrap silently. count = DEPTH addresses the oldest word, which is the slot at waddr.
- Full with wen & fire in the same cycle: the write is accepted into the slot being read, count is unchanged, overflow stays 0.
- Drain: with wen=0 and rdy=1, valid stays high for exactly count cycles, then the state returns to FILL.
- LAG = 1: valid on the cycle after the first write.

## Structure
- Shared package lbmem_pkg:
  - state enum {FILL, STREAM}
  - clog2 constant function
  - a derived-width localparam helper for count and address widths
- Sub-module lbmem_ram: simple dual-port, WIDTH×DEPTH, synchronous write, asynchronous read, no reset.
- lbmem_n contains the control logic: FSM, count, waddr, flags.

## Test plan
Defaults for all scenarios: WIDTH=16, DEPTH=64, LAG=8.
1. Reset, then write 0..7 on consecutive cycles with rdy=1 → valid=0 through the 8th write edge; next cycle valid=1, rdata=0, count=8.
2. Continuous wen=1, rdy=1, wdata=n for n=0..199 → from cycle 8 on, rdata = wdata − 8 every cycle, count constant 8, wrap past waddr 63 is correct.
3. After scenario 1, wen=0, rdy=1 → rdata 0..7 on 8 consecutive cycles, then valid=0, count=0. Writing 7 more words keeps valid=0; the 8th raises valid.
4. rdy=0, write 0..63 → full=1 after the 64th write. A 65th write (wdata=99) sets overflow=1 and rdata stays 0. Then rdy=1, wen=1, wdata=64 in one cycle → transfer of 0, write accepted, count stays 64, next rdata=1.
5. Mid-stream with count=8, assert flush together with wen → next cycle valid=0, count=0, overflow=0, waddr unchanged. 8 new writes are required before valid returns.
6. Drop RESETN asynchronously mid-stream with count=5 → all outputs return to reset values immediately, without waiting for a clock edge. After release, behaviour matches scenario 1.
